// File: rtl/mosby_mem_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state codes,
// bus owner and the starvation limit for the fetch port.
package mosby_mem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_t;

    localparam int STARVE_LIMIT = 3;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the byte-wide bus-access stage signals.
// master = arbiter side, slave = requesters / memory side.
interface mem_arbiter_if;
    logic        if_req;
    logic        if_gnt;
    logic        if_done;
    logic        ex_req;
    logic        ex_we;
    logic        ex_wide;
    logic [15:0] ex_addr;
    logic [15:0] ex_wdata;
    logic        ex_gnt;
    logic        ex_done;
    logic [15:0] ex_rdata;
    logic        mem_en;
    logic        mem_pc_sel;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    modport master (
        input  if_req, ex_req, ex_we, ex_wide, ex_addr, ex_wdata, mem_rdata,
        output if_gnt, if_done, ex_gnt, ex_done, ex_rdata,
               mem_en, mem_pc_sel, mem_wr, mem_addr, mem_wdata, busy
    );

    modport slave (
        output if_req, ex_req, ex_we, ex_wide, ex_addr, ex_wdata, mem_rdata,
        input  if_gnt, if_done, ex_gnt, ex_done, ex_rdata,
               mem_en, mem_pc_sel, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick (execute over fetch) with a starvation guard that hands
// the bus to fetch after STARVE_LIMIT back-to-back execute grants.
module mem_arb_pick
    import mosby_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req,
    input  logic   ex_req,
    input  logic   arb_en,
    output logic   any_req,
    output owner_t owner
);
    logic [STARVE_W-1:0] starve_reg;
    logic                starved;

    assign starved = (starve_reg == STARVE_W'(STARVE_LIMIT));
    assign any_req = if_req | ex_req;
    assign owner   = (if_req && (!ex_req || starved)) ? OWN_IF : OWN_EX;

    // Counts execute grants taken while fetch was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_reg <= '0;
        end else if (!if_req) begin
            starve_reg <= '0;
        end else if (arb_en && any_req) begin
            if (owner == OWN_IF) begin
                starve_reg <= '0;
            end else if (!starved) begin
                starve_reg <= starve_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide bus-access stage between instruction fetch and the
// execute unit; 16-bit execute accesses are split into two byte cycles.
module mem_arbiter
    import mosby_mem_pkg::*;
(
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    logic [1:0]  state_reg;
    owner_t      owner_reg;
    logic        we_reg;
    logic        wide_reg;
    logic [15:0] addr_reg;
    logic [7:0]  wdata_hi_reg;
    logic [7:0]  rdata_lo_reg;
    logic        if_gnt_reg, if_done_reg, ex_gnt_reg, ex_done_reg;
    logic [15:0] ex_rdata_reg;
    logic        mem_en_reg, mem_pc_sel_reg, mem_wr_reg, busy_reg;
    logic [15:0] mem_addr_reg;
    logic [7:0]  mem_wdata_reg;

    logic        any_req;
    owner_t      pick_owner;
    logic        grant_ex;

    mem_arb_pick u_pick (
        .clk     (clk),
        .rst     (rst),
        .if_req  (bus.if_req),
        .ex_req  (bus.ex_req),
        .arb_en  (state_reg == ST_IDLE),
        .any_req (any_req),
        .owner   (pick_owner)
    );

    assign grant_ex = (pick_owner == OWN_EX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_IF;
            we_reg         <= 1'b0;
            wide_reg       <= 1'b0;
            addr_reg       <= '0;
            wdata_hi_reg   <= '0;
            rdata_lo_reg   <= '0;
            if_gnt_reg     <= 1'b0;
            if_done_reg    <= 1'b0;
            ex_gnt_reg     <= 1'b0;
            ex_done_reg    <= 1'b0;
            ex_rdata_reg   <= '0;
            mem_en_reg     <= 1'b0;
            mem_pc_sel_reg <= 1'b0;
            mem_wr_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            if_gnt_reg  <= 1'b0;
            ex_gnt_reg  <= 1'b0;
            if_done_reg <= 1'b0;
            ex_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        // Fetch is always a narrow read from the PC.
                        state_reg      <= ST_ACC0;
                        busy_reg       <= 1'b1;
                        owner_reg      <= pick_owner;
                        we_reg         <= grant_ex & bus.ex_we;
                        wide_reg       <= grant_ex & bus.ex_wide;
                        addr_reg       <= bus.ex_addr;
                        wdata_hi_reg   <= bus.ex_wdata[15:8];
                        if_gnt_reg     <= ~grant_ex;
                        ex_gnt_reg     <= grant_ex;
                        mem_en_reg     <= 1'b1;
                        mem_pc_sel_reg <= ~grant_ex;
                        mem_wr_reg     <= grant_ex & bus.ex_we;
                        mem_addr_reg   <= bus.ex_addr;
                        mem_wdata_reg  <= bus.ex_wdata[7:0];
                    end
                end
                ST_ACC0: begin
                    if (!we_reg) begin
                        rdata_lo_reg <= bus.mem_rdata;
                    end
                    if (wide_reg) begin
                        state_reg     <= ST_ACC1;
                        mem_addr_reg  <= addr_reg + 16'd1;
                        mem_wdata_reg <= wdata_hi_reg;
                    end else begin
                        state_reg      <= ST_DONE;
                        mem_en_reg     <= 1'b0;
                        mem_pc_sel_reg <= 1'b0;
                        mem_wr_reg     <= 1'b0;
                        if_done_reg    <= (owner_reg == OWN_IF);
                        ex_done_reg    <= (owner_reg == OWN_EX);
                        if (!we_reg) begin
                            ex_rdata_reg <= {8'h00, bus.mem_rdata};
                        end
                    end
                end
                ST_ACC1: begin
                    // Only execute accesses reach here.
                    state_reg      <= ST_DONE;
                    mem_en_reg     <= 1'b0;
                    mem_pc_sel_reg <= 1'b0;
                    mem_wr_reg     <= 1'b0;
                    ex_done_reg    <= 1'b1;
                    if (!we_reg) begin
                        ex_rdata_reg <= {bus.mem_rdata, rdata_lo_reg};
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_gnt     = if_gnt_reg;
    assign bus.if_done    = if_done_reg;
    assign bus.ex_gnt     = ex_gnt_reg;
    assign bus.ex_done    = ex_done_reg;
    assign bus.ex_rdata   = ex_rdata_reg;
    assign bus.mem_en     = mem_en_reg;
    assign bus.mem_pc_sel = mem_pc_sel_reg;
    assign bus.mem_wr     = mem_wr_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.busy       = busy_reg;

endmodule
